// File: rtl/aes_spi_host_sequencer.sv
// aes_spi_host_sequencer: byte-sequences an AES job (text, key size, key, 16 dummy reads) through the SPI master.
module aes_spi_host_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [1:0]   mode,
  input  logic [127:0] text_in,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         resp_valid,
  output logic [127:0] resp_data,
  output logic         error,
  output logic         m_start,
  output logic [7:0]   m_data_in,
  input  logic [7:0]   m_data_out,
  input  logic         m_busy,
  input  logic         m_done,
  input  logic         slave_ready
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WAIT_RDY, RESULT} state_t;
  state_t state_q, state_d;
  logic [391:0] tx_q, tx_d;
  logic [5:0] k_q, k_d, k_in;
  logic [6:0] cnt_q, cnt_d, rx_base;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [127:0] rd_q, rd_d;
  logic err_q, err_d, start_q, start_d;
  logic [7:0] din_q, din_d;
  logic [3:0] rx_idx;
  logic [255:0] key_l;
  logic tmo_hit;
  assign k_in = mode == 2'b00 ? 6'd16 : mode == 2'b01 ? 6'd24 : 6'd32;
  // Left-align the used key portion so the whole frame shifts out MSB-first.
  assign key_l = mode == 2'b00 ? {key_in[127:0], 128'b0} : mode == 2'b01 ? {key_in[191:0], 64'b0} : key_in;
  assign rx_base = 7'(k_q) + 7'd17;
  assign rx_idx = 4'(cnt_q - rx_base);
  assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES);
  assign busy = state_q != IDLE;
  assign resp_valid = state_q == RESULT;
  assign resp_data = rd_q;
  assign error = err_q;
  assign m_start = start_q;
  assign m_data_in = din_q;
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    k_d = k_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    rd_d = rd_q;
    err_d = err_q;
    din_d = din_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        err_d = mode == 2'b11;
        state_d = mode == 2'b11 ? RESULT : ISSUE;
        if (mode != 2'b11) begin
          tx_d = {text_in, 2'b00, k_in, key_l};
          k_d = k_in;
          cnt_d = '0;
          rd_d = '0;
        end
      end
      ISSUE: if (!m_busy) begin
        start_d = 1'b1;
        din_d = cnt_q < rx_base ? tx_q[391:384] : DUMMY_BYTE;
        tx_d = tx_q << 8;
        tmo_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: if (m_done) begin
        if (cnt_q >= rx_base) rd_d[{~rx_idx, 3'b000} +: 8] = m_data_out;
        cnt_d = cnt_q + 7'd1;
        state_d = cnt_q == 7'(k_q) + 7'd32 ? RESULT : WAIT_RDY;
      end else if (tmo_hit) begin
        err_d = 1'b1;
        state_d = RESULT;
      end else tmo_d = tmo_q + 1'b1;
      WAIT_RDY: if (slave_ready) state_d = ISSUE;
      else if (tmo_hit) begin
        err_d = 1'b1;
        state_d = RESULT;
      end else tmo_d = tmo_q + 1'b1;
      RESULT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      rd_q <= '0;
      err_q <= 1'b0;
      din_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      rd_q <= rd_d;
      err_q <= err_d;
      din_q <= din_d;
      start_q <= start_d;
    end
  end
endmodule

// File: tb/tb_aes_spi_host_sequencer.sv
// tb_aes_spi_host_sequencer: randomized jobs against an SPI master/AES slave model and a frame-level reference.
module tb_aes_spi_host_sequencer;
  logic clk = 1'b0;
  logic reset, req, busy, resp_valid, error, m_start, m_busy, m_done, slave_ready;
  logic [1:0] mode;
  logic [127:0] text_in, resp_data;
  logic [255:0] key_in;
  logic [7:0] m_data_in, m_data_out;
  logic t_req, t_busy, t_valid, t_err, t_start;
  logic [127:0] t_data;
  logic [7:0] t_din;
  int checks = 0, failures = 0;
  logic [7:0] stream[$];
  logic [127:0] ct = '0;
  int kk = 16;
  bit stall = 1'b0;

  always #5 clk = ~clk;

  aes_spi_host_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode), .text_in(text_in), .key_in(key_in),
    .busy(busy), .resp_valid(resp_valid), .resp_data(resp_data), .error(error),
    .m_start(m_start), .m_data_in(m_data_in), .m_data_out(m_data_out), .m_busy(m_busy),
    .m_done(m_done), .slave_ready(slave_ready)
  );

  aes_spi_host_sequencer #(.TIMEOUT_CYCLES(50)) dut_t (
    .clk(clk), .reset(reset), .req(t_req), .mode(2'b00), .text_in(128'h0), .key_in(256'h0),
    .busy(t_busy), .resp_valid(t_valid), .resp_data(t_data), .error(t_err),
    .m_start(t_start), .m_data_in(t_din), .m_data_out(8'h00), .m_busy(1'b0),
    .m_done(1'b0), .slave_ready(1'b0)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SPI master + AES slave: records each sent byte, answers after a random latency.
  initial begin
    int dly, idx;
    logic [7:0] rsp;
    dly = 0;
    rsp = 8'h00;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_data_out = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      m_done = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_data_out = rsp;
        end
      end else if (m_start) begin
        idx = stream.size() - 17 - kk;
        stream.push_back(m_data_in);
        rsp = (idx >= 0 && idx < 16) ? ct[8*(15-idx) +: 8] : 8'($urandom);
        m_busy = 1'b1;
        dly = $urandom_range(1, 4);
      end
    end
  end

  initial begin
    slave_ready = 1'b0;
    forever begin
      @(negedge clk);
      slave_ready = !stall && ($urandom_range(0, 3) != 0);
    end
  end

  task automatic run_job(input logic [1:0] md, input logic [127:0] tx, input logic [255:0] ky,
                         input logic [127:0] c, input bit do_stall, input bit hammer);
    logic [7:0] exp[$];
    int k, n, nv, sz;
    bit stalled;
    logic [127:0] got_d;
    logic got_e;
    k = 16 + 8 * int'(md);
    for (int i = 0; i < 16; i++) exp.push_back(tx[8*(15-i) +: 8]);
    exp.push_back(8'(k));
    for (int i = 0; i < k; i++) exp.push_back(ky[8*(k-1-i) +: 8]);
    repeat (16) exp.push_back(8'h00);
    stream.delete();
    kk = k;
    ct = c;
    stalled = 1'b0;
    @(negedge clk);
    mode = md;
    text_in = tx;
    key_in = ky;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    mode = 2'($urandom);
    text_in = {$urandom, $urandom, $urandom, $urandom};
    key_in = {8{$urandom}};
    n = 0;
    while (!resp_valid && n < 20000) begin
      @(negedge clk);
      n++;
      if (hammer) req = 1'($urandom_range(0, 1));
      if (do_stall && !stalled && stream.size() >= 21) begin
        stall = 1'b1;
        stalled = 1'b1;
        sz = stream.size();
        repeat (100) @(negedge clk);
        check("stall_no_start", 128'(stream.size()), 128'(sz));
        stall = 1'b0;
      end
    end
    req = 1'b0;
    check("job_finished", 128'(resp_valid), 128'(1));
    got_d = resp_data;
    got_e = error;
    nv = resp_valid ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) nv++;
    end
    check("resp_valid_count", 128'(nv), 128'(1));
    check("busy_after", 128'(busy), 128'(0));
    check("error", 128'(got_e), 128'(0));
    check("error_hold", 128'(error), 128'(0));
    check("resp_data", got_d, c);
    check("transfers", 128'(stream.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size() && i < stream.size(); i++)
      check($sformatf("byte%0d", i), 128'(stream[i]), 128'(exp[i]));
  endtask

  initial begin
    int n, ns;
    reset = 1'b1;
    req = 1'b0;
    t_req = 1'b0;
    mode = 2'b00;
    text_in = '0;
    key_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(resp_valid), 128'(0));
    check("rst_error", 128'(error), 128'(0));
    check("rst_data", resp_data, 128'(0));
    check("rst_start", 128'(m_start), 128'(0));
    check("rst_din", 128'(m_data_in), 128'(0));

    run_job(2'b10, 128'h00112233445566778899aabbccddeeff,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            128'h8ea2b7ca516745bfeafc49904b496089, 1'b0, 1'b0);
    run_job(2'b00, 128'h00112233445566778899aabbccddeeff,
            {128'hdeadbeefcafef00d0123456789abcdef, 128'h000102030405060708090a0b0c0d0e0f},
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++)
      run_job(2'(j), {$urandom, $urandom, $urandom, $urandom}, {8{$urandom}},
              {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    run_job(2'($urandom_range(0, 2)), {$urandom, $urandom, $urandom, $urandom}, {8{$urandom}},
            {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    run_job(2'($urandom_range(0, 2)), {$urandom, $urandom, $urandom, $urandom}, {8{$urandom}},
            {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);

    // Invalid key size: immediate error response, nothing sent.
    stream.delete();
    @(negedge clk);
    mode = 2'b11;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("inv_valid", 128'(resp_valid), 128'(1));
    check("inv_error", 128'(error), 128'(1));
    @(negedge clk);
    check("inv_valid_once", 128'(resp_valid), 128'(0));
    check("inv_busy", 128'(busy), 128'(0));
    check("inv_error_hold", 128'(error), 128'(1));
    check("inv_no_start", 128'(stream.size()), 128'(0));

    // Reset in the middle of transfer 30.
    stream.delete();
    kk = 16;
    ct = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    mode = 2'b00;
    text_in = {$urandom, $urandom, $urandom, $urandom};
    key_in = {8{$urandom}};
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (stream.size() < 31 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", 128'(stream.size() >= 31), 128'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_busy", 128'(busy), 128'(0));
    check("mid_start", 128'(m_start), 128'(0));
    check("mid_valid", 128'(resp_valid), 128'(0));
    check("mid_error", 128'(error), 128'(0));
    check("mid_data", resp_data, 128'(0));
    check("mid_din", 128'(m_data_in), 128'(0));
    ns = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid || m_start) ns++;
    end
    check("mid_quiet", 128'(ns), 128'(0));
    run_job(2'b01, {$urandom, $urandom, $urandom, $urandom}, {8{$urandom}},
            {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

    // Timeout instance: the master never answers.
    @(negedge clk);
    t_req = 1'b1;
    @(negedge clk);
    t_req = 1'b0;
    n = 1;
    ns = 0;
    while (!t_valid && n < 200) begin
      if (t_start) ns++;
      @(negedge clk);
      n++;
    end
    check("tmo_valid", 128'(t_valid), 128'(1));
    check("tmo_latency", 128'(n >= 50 && n <= 56), 128'(1));
    check("tmo_error", 128'(t_err), 128'(1));
    check("tmo_starts", 128'(ns), 128'(1));
    check("tmo_data", t_data, 128'(0));
    @(negedge clk);
    check("tmo_busy", 128'(t_busy), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
